prog_mem_ctrl: RTL

Parametrised program-memory controller that replaces the fixed 8×16 loader/fetch memory between the host load port and the processor. A host fills the memory sequentially through a load strobe, then hands control to the processor. The processor fetches words by address through a one-cycle request/valid handshake. The block also has a timed clear sweep, a load-full flag, an exposed state, and a muxed debug address output.

---
 rtl/prog_mem_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: host-loaded program memory with a timed clear sweep and a 1-cycle fetch port.
// Build option PMEM_WRAP_EN: once full, the load pointer wraps to 0 instead of saturating.
module prog_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              status,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              addr_mux,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              full,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] address
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        LOAD  = 2'b10,
        RUN   = 2'b11
    } state_t;

    state_t            st_q;
    state_t            st_d;
    logic [ADDR_W-1:0] ld_ptr_q;
    logic [ADDR_W-1:0] ld_ptr_d;
    logic [ADDR_W-1:0] ld_next;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W-1:0] clr_ptr_d;
    logic              full_q;
    logic              full_d;
    logic              ld_ok;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              fetch_acc;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef PMEM_WRAP_EN
    assign ld_ok   = 1'b1;
    assign ld_next = ld_ptr_q + ADDR_W'(1);
`else
    // Once full, the pointer parks on the last word and loads are dropped.
    assign ld_ok   = !full_q;
    assign ld_next = (ld_ptr_q == LAST) ? LAST : ld_ptr_q + ADDR_W'(1);
`endif

    assign fetch_acc = (st_q == RUN) && fetch_req;

    always_comb begin
        st_d      = st_q;
        ld_ptr_d  = ld_ptr_q;
        clr_ptr_d = clr_ptr_q;
        full_d    = full_q;
        we        = 1'b0;
        wa        = ld_ptr_q;
        wd        = ld_data;
        unique case (st_q)
            IDLE, LOAD: begin
                if (clr) begin
                    st_d = CLEAR;
                end else if (st_q == IDLE && status) begin
                    st_d = RUN;
                end else begin
                    if (ld && ld_ok) begin
                        we       = 1'b1;
                        ld_ptr_d = ld_next;
                        full_d   = full_q | (ld_ptr_q == LAST);
                    end
                    if (status) begin
                        st_d = RUN;
                    end else if (ld) begin
                        st_d = LOAD;
                    end
                end
            end
            CLEAR: begin
                we        = 1'b1;
                wa        = clr_ptr_q;
                wd        = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST) begin
                    st_d     = IDLE;
                    ld_ptr_d = '0;
                    full_d   = 1'b0;
                end
            end
            RUN: begin
                if (clr) begin
                    st_d = CLEAR;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q        <= IDLE;
            ld_ptr_q    <= '0;
            clr_ptr_q   <= '0;
            full_q      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else begin
            st_q        <= st_d;
            ld_ptr_q    <= ld_ptr_d;
            clr_ptr_q   <= clr_ptr_d;
            full_q      <= full_d;
            fetch_valid <= fetch_acc;
            if (fetch_acc) begin
                fetch_data <= mem[fetch_addr];
            end
        end
    end

    // Array itself is never reset; a reset edge only suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && we) begin
            mem[wa] <= wd;
        end
    end

    assign state   = st_q;
    assign ld_addr = ld_ptr_q;
    assign full    = full_q;
    assign address = addr_mux ? fetch_addr : ld_ptr_q;

endmodule
